// File: rtl/snn_seq_ctrl_if.sv
// Handshake and buffer-strobe bundle between the SNN sequencer and its environment.
// SNN_SEQ_PERF_EN adds the perf_cyc observation port.
interface snn_seq_ctrl_if;
  logic       in_valid;
  logic [1:0] opt;
  logic       dp_stall;
  logic       img_we;
  logic [6:0] img_waddr;
  logic       ker_we;
  logic [4:0] ker_waddr;
  logic       wgt_we;
  logic [1:0] wgt_waddr;
  logic [1:0] opt_q;
  logic       conv_issue;
  logic       conv_img;
  logic [3:0] conv_pos;
  logic       post_issue;
  logic [1:0] post_step;
  logic       out_valid;
  logic       busy;
  logic       err_in;
`ifdef SNN_SEQ_PERF_EN
  logic [7:0] perf_cyc;
`endif

  modport master (
    output in_valid, opt, dp_stall,
`ifdef SNN_SEQ_PERF_EN
    input  perf_cyc,
`endif
    input  img_we, img_waddr, ker_we, ker_waddr, wgt_we, wgt_waddr, opt_q,
           conv_issue, conv_img, conv_pos, post_issue, post_step,
           out_valid, busy, err_in
  );

  modport slave (
    input  in_valid, opt, dp_stall,
`ifdef SNN_SEQ_PERF_EN
    output perf_cyc,
`endif
    output img_we, img_waddr, ker_we, ker_waddr, wgt_we, wgt_waddr, opt_q,
           conv_issue, conv_img, conv_pos, post_issue, post_step,
           out_valid, busy, err_in
  );
endinterface

// File: rtl/snn_seq_ctrl.sv
// Sequencer for the SNN FP datapath: burst capture, conv/post issue, drains, result strobe.
// Optional SNN_SEQ_PERF_EN: saturating 8-bit cycle counter from first CONV cycle through OUT.
module snn_seq_ctrl #(
  parameter int IMG_WORDS = 96,
  parameter int KER_WORDS = 27,
  parameter int WGT_WORDS = 4,
  parameter int CONV_OPS  = 32,
  parameter int POST_OPS  = 4,
  parameter int FP_LAT    = 2
) (
  input  logic          clk,
  input  logic          rst,
  snn_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CONV, S_DRAIN1, S_POST, S_DRAIN2, S_OUT
  } state_e;

  localparam logic [6:0] IMG_LAST  = 7'(IMG_WORDS - 1);
  localparam logic [6:0] CONV_LAST = 7'(CONV_OPS - 1);
  localparam logic [6:0] POST_LAST = 7'(POST_OPS - 1);
  localparam logic [6:0] LAT_LAST  = 7'(FP_LAT - 1);
  localparam logic [6:0] KER_N     = 7'(KER_WORDS);
  localparam logic [6:0] WGT_N     = 7'(WGT_WORDS);

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [1:0] opt_lat_q, opt_lat_d;

  // One shared counter: load index, conv k, drain cycles and post step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opt_lat_d = opt_lat_q;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) begin
        state_d   = S_LOAD;
        cnt_d     = 7'd1;
        opt_lat_d = bus.opt;
      end
      S_LOAD: begin
        if (!bus.in_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == IMG_LAST) begin
          state_d = S_CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_CONV: if (!bus.dp_stall) begin
        if (cnt_q == CONV_LAST) begin
          state_d = S_DRAIN1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DRAIN1: begin
        if (cnt_q == LAT_LAST) begin
          state_d = S_POST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_POST: if (!bus.dp_stall) begin
        if (cnt_q == POST_LAST) begin
          state_d = S_DRAIN2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DRAIN2: begin
        if (cnt_q == LAT_LAST) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opt_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opt_lat_q <= opt_lat_d;
    end
  end

  // Strobes are combinational so a word lands in the buffer on its arrival cycle;
  // cnt_q is 0 in IDLE, which makes the first burst cycle address 0.
  logic load_ok, ker_ok, wgt_ok, conv_ok, post_ok, run_st;
  assign load_ok = bus.in_valid && (state_q == S_IDLE || state_q == S_LOAD);
  assign ker_ok  = load_ok && (cnt_q < KER_N);
  assign wgt_ok  = load_ok && (cnt_q < WGT_N);
  assign conv_ok = (state_q == S_CONV) && !bus.dp_stall;
  assign post_ok = (state_q == S_POST) && !bus.dp_stall;
  assign run_st  = state_q inside {S_CONV, S_DRAIN1, S_POST, S_DRAIN2, S_OUT};

  assign bus.img_we     = load_ok;
  assign bus.img_waddr  = load_ok ? cnt_q : '0;
  assign bus.ker_we     = ker_ok;
  assign bus.ker_waddr  = ker_ok ? cnt_q[4:0] : '0;
  assign bus.wgt_we     = wgt_ok;
  assign bus.wgt_waddr  = wgt_ok ? cnt_q[1:0] : '0;
  assign bus.opt_q      = opt_lat_q;
  assign bus.conv_issue = conv_ok;
  assign bus.conv_img   = conv_ok & cnt_q[4];
  assign bus.conv_pos   = conv_ok ? cnt_q[3:0] : '0;
  assign bus.post_issue = post_ok;
  assign bus.post_step  = post_ok ? cnt_q[1:0] : '0;
  assign bus.out_valid  = (state_q == S_OUT) && !bus.in_valid;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err_in     = ((state_q == S_LOAD) && !bus.in_valid) || (bus.in_valid && run_st);

`ifdef SNN_SEQ_PERF_EN
  logic [7:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_LOAD && state_d == S_CONV) perf_d = '0;
    else if (run_st && perf_q != 8'hff)         perf_d = perf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign bus.perf_cyc = perf_q;
`endif

endmodule
